rs_station: RTL and testbench

- Reservation station directly downstream of the register status table in the Tomasulo core.
- Accepts issued instructions carrying source tags q1/q2 read from the status table, plus operand values for sources already resolved.
- Snoops the common data bus (CDB) to capture pending operands, then dispatches the oldest fully-ready entry to one functional unit over a valid/ready handshake.
- Each entry's 6-bit tag is what the issue logic writes into the status table as the producer of the destination register.

---
 rtl/rs_station_if.sv | 42 ++++
 rtl/rs_station.sv | 119 +++++++++++
 tb/tb_rs_station.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/rs_station_if.sv
// Issue, CDB snoop and functional-unit dispatch signals of one reservation station.
// The station takes the slave side; the issue stage, CDB and FU take the master side.
interface rs_station_if #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 6
);
    logic              issue_valid;
    logic              issue_ready;
    logic [OP_W-1:0]   issue_op;
    logic [5:0]        issue_q1;
    logic [5:0]        issue_q2;
    logic [DATA_W-1:0] issue_v1;
    logic [DATA_W-1:0] issue_v2;
    logic [5:0]        issue_tag;

    logic              cdb_valid;
    logic [5:0]        cdb_tag;
    logic [DATA_W-1:0] cdb_data;

    logic              fu_valid;
    logic              fu_ready;
    logic [OP_W-1:0]   fu_op;
    logic [DATA_W-1:0] fu_a;
    logic [DATA_W-1:0] fu_b;
    logic [5:0]        fu_tag;

    modport slave (
        input  issue_valid, issue_op, issue_q1, issue_q2, issue_v1, issue_v2,
        output issue_ready, issue_tag,
        input  cdb_valid, cdb_tag, cdb_data,
        output fu_valid, fu_op, fu_a, fu_b, fu_tag,
        input  fu_ready
    );

    modport master (
        output issue_valid, issue_op, issue_q1, issue_q2, issue_v1, issue_v2,
        input  issue_ready, issue_tag,
        output cdb_valid, cdb_tag, cdb_data,
        input  fu_valid, fu_op, fu_a, fu_b, fu_tag,
        output fu_ready
    );
endinterface

// File: rtl/rs_station.sv
// Tomasulo reservation station: holds issued ops, snoops the CDB for pending operands
// and dispatches the oldest fully-ready entry to one functional unit.
module rs_station #(
    parameter int         DEPTH     = 4,
    parameter logic [5:0] TAG_BASE  = 6'd0,
    parameter logic [5:0] TAG_READY = 6'b010000,
    parameter int         DATA_W    = 32,
    parameter int         OP_W      = 6
) (
    input  logic         clk,
    input  logic         rst,
    rs_station_if.slave  rs
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic              busy;
        logic [OP_W-1:0]   op;
        logic [5:0]        q1;
        logic [5:0]        q2;
        logic [DATA_W-1:0] v1;
        logic [DATA_W-1:0] v2;
        logic [2:0]        age;
    } entry_t;

    entry_t [DEPTH-1:0] ent_q, ent_d;

    logic             free_found;
    logic [IDX_W-1:0] free_idx;
    logic [3:0]       busy_cnt;
    logic             sel_found;
    logic [IDX_W-1:0] sel_idx;
    logic [2:0]       sel_age;
    logic             accept, fire, cdb_hit;
    logic [2:0]       new_age;

    // Free slot, occupancy and oldest-ready selection all look at registered state only.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        busy_cnt   = '0;
        sel_found  = 1'b0;
        sel_idx    = '0;
        sel_age    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_q[i].busy) busy_cnt = busy_cnt + 4'd1;
            if (!ent_q[i].busy && !free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
            if (ent_q[i].busy && ent_q[i].q1 == TAG_READY && ent_q[i].q2 == TAG_READY &&
                (!sel_found || ent_q[i].age < sel_age)) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
                sel_age   = ent_q[i].age;
            end
        end
    end

    assign rs.issue_ready = free_found;
    assign rs.issue_tag   = TAG_BASE + 6'(free_idx);
    assign rs.fu_valid    = sel_found;
    assign rs.fu_op       = sel_found ? ent_q[sel_idx].op : '0;
    assign rs.fu_a        = sel_found ? ent_q[sel_idx].v1 : '0;
    assign rs.fu_b        = sel_found ? ent_q[sel_idx].v2 : '0;
    assign rs.fu_tag      = sel_found ? TAG_BASE + 6'(sel_idx) : '0;

    assign accept  = rs.issue_valid && free_found;
    assign fire    = sel_found && rs.fu_ready;
    assign cdb_hit = rs.cdb_valid && (rs.cdb_tag != TAG_READY);
    // The dispatched entry leaves in the same edge, so a co-issued op lands one age lower.
    assign new_age = fire ? 3'(busy_cnt - 4'd1) : 3'(busy_cnt);

    always_comb begin
        ent_d = ent_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_q[i].busy && cdb_hit) begin
                if (ent_q[i].q1 == rs.cdb_tag) begin
                    ent_d[i].q1 = TAG_READY;
                    ent_d[i].v1 = rs.cdb_data;
                end
                if (ent_q[i].q2 == rs.cdb_tag) begin
                    ent_d[i].q2 = TAG_READY;
                    ent_d[i].v2 = rs.cdb_data;
                end
            end
            if (fire && ent_q[i].busy) begin
                if (IDX_W'(i) == sel_idx)
                    ent_d[i].busy = 1'b0;
                else if (ent_q[i].age > sel_age)
                    ent_d[i].age = ent_q[i].age - 3'd1;
            end
            if (accept && IDX_W'(i) == free_idx) begin
                ent_d[i].busy = 1'b1;
                ent_d[i].op   = rs.issue_op;
                ent_d[i].age  = new_age;
                if (cdb_hit && rs.issue_q1 == rs.cdb_tag) begin
                    ent_d[i].q1 = TAG_READY;
                    ent_d[i].v1 = rs.cdb_data;
                end else begin
                    ent_d[i].q1 = rs.issue_q1;
                    ent_d[i].v1 = rs.issue_v1;
                end
                if (cdb_hit && rs.issue_q2 == rs.cdb_tag) begin
                    ent_d[i].q2 = TAG_READY;
                    ent_d[i].v2 = rs.cdb_data;
                end else begin
                    ent_d[i].q2 = rs.issue_q2;
                    ent_d[i].v2 = rs.issue_v2;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) ent_q <= '0;
        else     ent_q <= ent_d;
    end
endmodule

// File: tb/tb_rs_station.sv
// Scenario bench for rs_station: dispatches are checked against a queue of expected
// {tag, op, a, b} tuples pushed in the order the station must offer them.
module tb_rs_station;
    localparam logic [5:0] R = 6'b010000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    logic [75:0] exp_q[$];

    always #5 clk = ~clk;

    rs_station_if #(.DATA_W(32), .OP_W(6)) bus ();
    rs_station dut (.clk(clk), .rst(rst), .rs(bus));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_issue(input logic [5:0] op, input logic [5:0] q1, input logic [5:0] q2,
                               input logic [31:0] v1, input logic [31:0] v2);
        bus.issue_valid = 1'b1;
        bus.issue_op    = op;
        bus.issue_q1    = q1;
        bus.issue_q2    = q2;
        bus.issue_v1    = v1;
        bus.issue_v2    = v2;
    endtask

    task automatic push_exp(input logic [5:0] tag, input logic [5:0] op,
                            input logic [31:0] a, input logic [31:0] b);
        exp_q.push_back({tag, op, a, b});
    endtask

    // Every completed handshake must match the head of the expectation queue.
    always @(negedge clk) begin
        if (!rst && bus.fu_valid && bus.fu_ready) begin
            logic [75:0] got, want;
            got = {bus.fu_tag, bus.fu_op, bus.fu_a, bus.fu_b};
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL dispatch_unexpected got=%h", got);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    bad++;
                    $display("FAIL dispatch got=%h want=%h", got, want);
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        total++; if (bus.issue_ready !== 1'b1) begin bad++; $display("FAIL rst_issue_ready got=%b want=1", bus.issue_ready); end
        total++; if (bus.fu_valid !== 1'b0) begin bad++; $display("FAIL rst_fu_valid got=%b want=0", bus.fu_valid); end
        total++; if (bus.issue_tag !== 6'd0) begin bad++; $display("FAIL rst_issue_tag got=%0d want=0", bus.issue_tag); end
        total++; if ({bus.fu_op, bus.fu_a, bus.fu_b, bus.fu_tag} !== '0) begin bad++; $display("FAIL rst_fu_fields got=%h want=0", {bus.fu_op, bus.fu_a, bus.fu_b, bus.fu_tag}); end
    endtask

    task automatic test_basic();
        bus.fu_ready = 1'b1;
        drive_issue(6'h01, R, R, 32'd5, 32'd7);
        push_exp(6'd0, 6'h01, 32'd5, 32'd7);
        tick();
        bus.issue_valid = 1'b0;
        total++; if (bus.fu_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b want=1", bus.fu_valid); end
        total++; if (bus.fu_a !== 32'd5 || bus.fu_b !== 32'd7) begin bad++; $display("FAIL basic_ops got=%0d/%0d want=5/7", bus.fu_a, bus.fu_b); end
        total++; if (bus.fu_tag !== 6'd0) begin bad++; $display("FAIL basic_tag got=%0d want=0", bus.fu_tag); end
        tick();
        total++; if (bus.issue_ready !== 1'b1 || bus.fu_valid !== 1'b0) begin bad++; $display("FAIL basic_after got=%b/%b want=1/0", bus.issue_ready, bus.fu_valid); end
    endtask

    task automatic test_cdb_capture();
        drive_issue(6'h02, 6'd3, R, 32'd0, 32'd9);
        push_exp(6'd0, 6'h02, 32'h2A, 32'd9);
        tick();
        bus.issue_valid = 1'b0;
        total++; if (bus.fu_valid !== 1'b0) begin bad++; $display("FAIL cdb_pending got=%b want=0", bus.fu_valid); end
        tick();
        total++; if (bus.fu_valid !== 1'b0) begin bad++; $display("FAIL cdb_pending2 got=%b want=0", bus.fu_valid); end
        bus.cdb_valid = 1'b1; bus.cdb_tag = 6'd3; bus.cdb_data = 32'h2A;
        tick();
        bus.cdb_valid = 1'b0;
        total++; if (bus.fu_valid !== 1'b1 || bus.fu_a !== 32'h2A) begin bad++; $display("FAIL cdb_capture got=%b/%h want=1/2a", bus.fu_valid, bus.fu_a); end
        tick();
    endtask

    task automatic test_bypass();
        drive_issue(6'h03, 6'd9, R, 32'hFFFF, 32'd1);
        bus.cdb_valid = 1'b1; bus.cdb_tag = 6'd9; bus.cdb_data = 32'h11;
        push_exp(6'd0, 6'h03, 32'h11, 32'd1);
        tick();
        bus.issue_valid = 1'b0;
        bus.cdb_valid   = 1'b0;
        total++; if (bus.fu_valid !== 1'b1 || bus.fu_a !== 32'h11) begin bad++; $display("FAIL bypass got=%b/%h want=1/11", bus.fu_valid, bus.fu_a); end
        tick();
    endtask

    task automatic test_full();
        bus.fu_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_issue(6'(4 + i), 6'(20 + i), R, 32'hDEAD, 32'(i));
            total++; if (bus.issue_tag !== 6'(i)) begin bad++; $display("FAIL full_tag%0d got=%0d want=%0d", i, bus.issue_tag, i); end
            tick();
        end
        total++; if (bus.issue_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%b want=0", bus.issue_ready); end
        drive_issue(6'h3E, 6'd30, R, 32'd0, 32'd0);
        tick();
        bus.issue_valid = 1'b0;
        total++; if (bus.issue_ready !== 1'b0 || bus.fu_valid !== 1'b0) begin bad++; $display("FAIL full_ignored got=%b/%b want=0/0", bus.issue_ready, bus.fu_valid); end
        bus.cdb_valid = 1'b1; bus.cdb_tag = 6'd22; bus.cdb_data = 32'h100;
        tick();
        bus.cdb_valid = 1'b0;
        total++; if (bus.fu_valid !== 1'b1 || bus.fu_tag !== 6'd2) begin bad++; $display("FAIL full_release got=%b/%0d want=1/2", bus.fu_valid, bus.fu_tag); end
        push_exp(6'd2, 6'd6, 32'h100, 32'd2);
        bus.fu_ready = 1'b1;
        total++; if (bus.issue_ready !== 1'b0) begin bad++; $display("FAIL full_same_cycle got=%b want=0", bus.issue_ready); end
        tick();
        bus.fu_ready = 1'b0;
        total++; if (bus.issue_ready !== 1'b1 || bus.issue_tag !== 6'd2) begin bad++; $display("FAIL full_reuse got=%b/%0d want=1/2", bus.issue_ready, bus.issue_tag); end
        drive_issue(6'd8, R, R, 32'h55, 32'h66);
        tick();
        bus.issue_valid = 1'b0;
        // Release the three older pending entries; drain must follow issue order.
        bus.cdb_valid = 1'b1;
        bus.cdb_tag = 6'd20; bus.cdb_data = 32'hA0; tick();
        bus.cdb_tag = 6'd21; bus.cdb_data = 32'hA1; tick();
        bus.cdb_tag = 6'd23; bus.cdb_data = 32'hA3; tick();
        bus.cdb_valid = 1'b0;
        push_exp(6'd0, 6'd4, 32'hA0, 32'd0);
        push_exp(6'd1, 6'd5, 32'hA1, 32'd1);
        push_exp(6'd3, 6'd7, 32'hA3, 32'd3);
        push_exp(6'd2, 6'd8, 32'h55, 32'h66);
        bus.fu_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        bus.fu_ready = 1'b0;
        total++; if (bus.fu_valid !== 1'b0 || bus.issue_ready !== 1'b1) begin bad++; $display("FAIL full_drain got=%b/%b want=0/1", bus.fu_valid, bus.issue_ready); end
    endtask

    task automatic test_age_order();
        bus.fu_ready = 1'b1;
        drive_issue(6'd9, 6'd4, R, 32'd0, 32'd2);
        tick();
        drive_issue(6'd10, R, R, 32'hB1, 32'hB2);
        total++; if (bus.issue_tag !== 6'd1) begin bad++; $display("FAIL age_tag_b got=%0d want=1", bus.issue_tag); end
        push_exp(6'd1, 6'd10, 32'hB1, 32'hB2);
        tick();
        bus.issue_valid = 1'b0;
        total++; if (bus.fu_valid !== 1'b1 || bus.fu_tag !== 6'd1) begin bad++; $display("FAIL age_b_first got=%b/%0d want=1/1", bus.fu_valid, bus.fu_tag); end
        tick();
        bus.cdb_valid = 1'b1; bus.cdb_tag = 6'd4; bus.cdb_data = 32'h44;
        push_exp(6'd0, 6'd9, 32'h44, 32'd2);
        tick();
        bus.cdb_valid = 1'b0;
        total++; if (bus.fu_tag !== 6'd0) begin bad++; $display("FAIL age_a_next got=%0d want=0", bus.fu_tag); end
        tick();
        bus.fu_ready = 1'b0;
        drive_issue(6'd11, 6'd5, R, 32'd0, 32'd3);
        tick();
        drive_issue(6'd12, R, R, 32'hC1, 32'hC2);
        tick();
        bus.issue_valid = 1'b0;
        total++; if (bus.fu_valid !== 1'b1 || bus.fu_tag !== 6'd1) begin bad++; $display("FAIL age_offer_b got=%b/%0d want=1/1", bus.fu_valid, bus.fu_tag); end
        bus.cdb_valid = 1'b1; bus.cdb_tag = 6'd5; bus.cdb_data = 32'h55;
        tick();
        bus.cdb_valid = 1'b0;
        total++; if (bus.fu_tag !== 6'd0 || bus.fu_a !== 32'h55) begin bad++; $display("FAIL age_switch got=%0d/%h want=0/55", bus.fu_tag, bus.fu_a); end
        push_exp(6'd0, 6'd11, 32'h55, 32'd3);
        push_exp(6'd1, 6'd12, 32'hC1, 32'hC2);
        bus.fu_ready = 1'b1;
        tick();
        tick();
        bus.fu_ready = 1'b0;
        total++; if (bus.fu_valid !== 1'b0) begin bad++; $display("FAIL age_empty got=%b want=0", bus.fu_valid); end
    endtask

    task automatic test_stall_reset();
        bus.fu_ready = 1'b0;
        drive_issue(6'h3F, R, R, 32'hDEAD, 32'hBEEF);
        tick();
        bus.issue_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++;
            if ({bus.fu_valid, bus.fu_op, bus.fu_a, bus.fu_b, bus.fu_tag} !== {1'b1, 6'h3F, 32'hDEAD, 32'hBEEF, 6'd0}) begin
                bad++;
                $display("FAIL stall%0d got=%b/%h/%h/%h/%0d want=1/3f/dead/beef/0", i, bus.fu_valid, bus.fu_op, bus.fu_a, bus.fu_b, bus.fu_tag);
            end
            tick();
        end
        rst = 1'b1;
        bus.fu_ready = 1'b1;
        tick();
        rst = 1'b0;
        bus.fu_ready = 1'b0;
        total++; if (bus.fu_valid !== 1'b0 || bus.issue_ready !== 1'b1) begin bad++; $display("FAIL mid_reset got=%b/%b want=0/1", bus.fu_valid, bus.issue_ready); end
        total++; if (bus.issue_tag !== 6'd0 || bus.fu_a !== 32'd0) begin bad++; $display("FAIL mid_reset_fields got=%0d/%h want=0/0", bus.issue_tag, bus.fu_a); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL leftover_expected got=%0d want=0", exp_q.size()); end
    endtask

    initial begin
        bus.issue_valid = 1'b0; bus.issue_op = '0; bus.issue_q1 = R; bus.issue_q2 = R;
        bus.issue_v1 = '0; bus.issue_v2 = '0;
        bus.cdb_valid = 1'b0; bus.cdb_tag = '0; bus.cdb_data = '0;
        bus.fu_ready = 1'b0;
        test_reset();
        test_basic();
        test_cdb_capture();
        test_bypass();
        test_full();
        test_age_order();
        test_stall_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
